// File: rtl/signal_conflict_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : signal_conflict_monitor
// Description : Safety stage between the traffic light controller and the
//               physical lamps. Passes legal aspects through with one cycle of
//               latency. Any conflicting or illegally encoded input is shown
//               as all-red at the next edge. A run of FAULT_CYCLES bad cycles
//               latches a flashing failsafe. Leaving failsafe needs
//               clear_fault with good inputs, followed by an all-red recovery
//               interval of RECOVER_CYCLES cycles.
// Ports       : clk                 system clock
//               rst                 asynchronous active-high reset
//               light_M1/M2/MT/S    controller aspects (001 G, 010 A, 100 R)
//               clear_fault         level request to leave failsafe
//               lamp_M1/M2/MT/S     registered lamp drives (000 = dark)
//               fault               failsafe latched
//               fault_code          {invalid, conflict} captured at latch
// Revision    : 1.0  initial release
// ============================================================================
module signal_conflict_monitor #(
    parameter int FAULT_CYCLES   = 2,
    parameter int BLINK_HALF     = 4,
    parameter int RECOVER_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_S,
    input  logic       clear_fault,
    output logic [2:0] lamp_M1,
    output logic [2:0] lamp_M2,
    output logic [2:0] lamp_MT,
    output logic [2:0] lamp_S,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam logic [2:0] c_GREEN = 3'b001;
    localparam logic [2:0] c_AMBER = 3'b010;
    localparam logic [2:0] c_RED   = 3'b100;
    localparam logic [2:0] c_DARK  = 3'b000;

    localparam int c_BAD_W   = $clog2(FAULT_CYCLES + 1);
    localparam int c_BLINK_W = $clog2(BLINK_HALF + 1);
    localparam int c_REC_W   = $clog2(RECOVER_CYCLES + 1);

    localparam logic [c_BAD_W-1:0]   c_BAD_LAST   = c_BAD_W'(FAULT_CYCLES - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_HALF - 1);
    localparam logic [c_REC_W-1:0]   c_REC_LAST   = c_REC_W'(RECOVER_CYCLES - 1);

    localparam logic [1:0] c_ST_RECOVER = 2'd0;
    localparam logic [1:0] c_ST_PASS    = 2'd1;
    localparam logic [1:0] c_ST_FLASH   = 2'd2;

    logic [1:0]           r_state;
    logic [c_BAD_W-1:0]   r_bad_cnt;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic [c_REC_W-1:0]   r_rec_cnt;
    logic                 r_phase_on;
    logic [2:0]           r_lamp_m1;
    logic [2:0]           r_lamp_m2;
    logic [2:0]           r_lamp_mt;
    logic [2:0]           r_lamp_s;
    logic                 r_fault;
    logic [1:0]           r_fault_code;

    logic w_invalid;
    logic w_conflict;
    logic w_bad;
    logic w_next_phase;

    function automatic logic f_valid(input logic [2:0] v);
        return (v == c_GREEN) || (v == c_AMBER) || (v == c_RED);
    endfunction

    // Green or amber both let traffic move, so both count as permissive.
    function automatic logic f_active(input logic [2:0] v);
        return v[0] | v[1];
    endfunction

    assign w_invalid  = !(f_valid(light_M1) && f_valid(light_M2) &&
                          f_valid(light_MT) && f_valid(light_S));
    assign w_conflict = (f_active(light_S) &
                         (f_active(light_M1) | f_active(light_M2) | f_active(light_MT)))
                      | (f_active(light_M2) & f_active(light_MT));
    assign w_bad      = w_invalid | w_conflict;

    // Phase the flash pattern will show after this edge.
    assign w_next_phase = (r_blink_cnt == c_BLINK_LAST) ? ~r_phase_on : r_phase_on;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_RECOVER;
            r_bad_cnt    <= '0;
            r_blink_cnt  <= '0;
            r_rec_cnt    <= '0;
            r_phase_on   <= 1'b1;
            r_lamp_m1    <= c_RED;
            r_lamp_m2    <= c_RED;
            r_lamp_mt    <= c_RED;
            r_lamp_s     <= c_RED;
            r_fault      <= 1'b0;
            r_fault_code <= 2'b00;
        end else begin
            case (r_state)
                c_ST_RECOVER: begin
                    if (w_bad) begin
                        r_rec_cnt <= '0;
                        r_lamp_m1 <= c_RED;
                        r_lamp_m2 <= c_RED;
                        r_lamp_mt <= c_RED;
                        r_lamp_s  <= c_RED;
                    end else if (r_rec_cnt == c_REC_LAST) begin
                        r_state      <= c_ST_PASS;
                        r_rec_cnt    <= '0;
                        r_bad_cnt    <= '0;
                        r_lamp_m1    <= light_M1;
                        r_lamp_m2    <= light_M2;
                        r_lamp_mt    <= light_MT;
                        r_lamp_s     <= light_S;
                        r_fault      <= 1'b0;
                        r_fault_code <= 2'b00;
                    end else begin
                        r_rec_cnt <= r_rec_cnt + 1'b1;
                        r_lamp_m1 <= c_RED;
                        r_lamp_m2 <= c_RED;
                        r_lamp_mt <= c_RED;
                        r_lamp_s  <= c_RED;
                    end
                end

                c_ST_PASS: begin
                    if (!w_bad) begin
                        r_bad_cnt <= '0;
                        r_lamp_m1 <= light_M1;
                        r_lamp_m2 <= light_M2;
                        r_lamp_mt <= light_MT;
                        r_lamp_s  <= light_S;
                    end else if (r_bad_cnt == c_BAD_LAST) begin
                        // Debounce expired: latch and show the first "on" pattern now.
                        r_state      <= c_ST_FLASH;
                        r_bad_cnt    <= '0;
                        r_blink_cnt  <= '0;
                        r_phase_on   <= 1'b1;
                        r_fault      <= 1'b1;
                        r_fault_code <= {w_invalid, w_conflict};
                        r_lamp_m1    <= c_AMBER;
                        r_lamp_m2    <= c_AMBER;
                        r_lamp_mt    <= c_AMBER;
                        r_lamp_s     <= c_RED;
                    end else begin
                        r_bad_cnt <= r_bad_cnt + 1'b1;
                        r_lamp_m1 <= c_RED;
                        r_lamp_m2 <= c_RED;
                        r_lamp_mt <= c_RED;
                        r_lamp_s  <= c_RED;
                    end
                end

                c_ST_FLASH: begin
                    if (clear_fault && !w_bad) begin
                        // fault/fault_code stay held until recovery completes.
                        r_state     <= c_ST_RECOVER;
                        r_rec_cnt   <= '0;
                        r_blink_cnt <= '0;
                        r_phase_on  <= 1'b1;
                        r_lamp_m1   <= c_RED;
                        r_lamp_m2   <= c_RED;
                        r_lamp_mt   <= c_RED;
                        r_lamp_s    <= c_RED;
                    end else begin
                        if (r_blink_cnt == c_BLINK_LAST) begin
                            r_blink_cnt <= '0;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + 1'b1;
                        end
                        r_phase_on <= w_next_phase;
                        r_lamp_m1  <= w_next_phase ? c_AMBER : c_DARK;
                        r_lamp_m2  <= w_next_phase ? c_AMBER : c_DARK;
                        r_lamp_mt  <= w_next_phase ? c_AMBER : c_DARK;
                        r_lamp_s   <= w_next_phase ? c_RED   : c_DARK;
                    end
                end

                default: begin
                    r_state   <= c_ST_RECOVER;
                    r_rec_cnt <= '0;
                    r_lamp_m1 <= c_RED;
                    r_lamp_m2 <= c_RED;
                    r_lamp_mt <= c_RED;
                    r_lamp_s  <= c_RED;
                end
            endcase
        end
    end

    assign lamp_M1    = r_lamp_m1;
    assign lamp_M2    = r_lamp_m2;
    assign lamp_MT    = r_lamp_mt;
    assign lamp_S     = r_lamp_s;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

endmodule
`default_nettype wire

// File: tb/tb_signal_conflict_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_signal_conflict_monitor
// Description : Self-checking bench for signal_conflict_monitor. Directed
//               scenarios followed by random stimulus, all compared against a
//               behavioural model of the monitor's rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_signal_conflict_monitor;

    localparam int FAULT_CYCLES   = 2;
    localparam int BLINK_HALF     = 4;
    localparam int RECOVER_CYCLES = 3;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] A = 3'b010;
    localparam logic [2:0] R = 3'b100;
    localparam logic [11:0] ALL_RED = {R, R, R, R};

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic       clear_fault;
    logic [2:0] lamp_M1, lamp_M2, lamp_MT, lamp_S;
    logic       fault;
    logic [1:0] fault_code;

    signal_conflict_monitor #(
        .FAULT_CYCLES  (FAULT_CYCLES),
        .BLINK_HALF    (BLINK_HALF),
        .RECOVER_CYCLES(RECOVER_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .light_M1   (light_M1),
        .light_M2   (light_M2),
        .light_MT   (light_MT),
        .light_S    (light_S),
        .clear_fault(clear_fault),
        .lamp_M1    (lamp_M1),
        .lamp_M2    (lamp_M2),
        .lamp_MT    (lamp_MT),
        .lamp_S     (lamp_S),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 = recovering (all red), 1 = normal pass-through, 2 = failsafe flash
    int          m_mode;
    int          m_good_run;   // consecutive good edges while recovering
    int          m_bad_run;    // consecutive bad edges while passing
    int          m_age;        // edges since the fault latched
    logic [11:0] m_lamps;
    logic        m_fault;
    logic [1:0]  m_code;

    function automatic logic legal(input logic [2:0] a);
        return (a == G) || (a == A) || (a == R);
    endfunction

    function automatic logic moving(input logic [2:0] a);
        return (a == G) || (a == A) || (a == 3'b011) || (a == 3'b101) ||
               (a == 3'b110) || (a == 3'b111);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_good_run = 0; m_bad_run = 0; m_age = 0;
        m_lamps = ALL_RED; m_fault = 1'b0; m_code = 2'b00;
    endtask

    task automatic model_edge();
        logic inv, conf, bad;
        inv  = !(legal(light_M1) && legal(light_M2) && legal(light_MT) && legal(light_S));
        conf = (moving(light_S) && (moving(light_M1) || moving(light_M2) || moving(light_MT)))
            || (moving(light_M2) && moving(light_MT));
        bad  = inv || conf;
        if (m_mode == 0) begin
            m_lamps    = ALL_RED;
            m_good_run = bad ? 0 : m_good_run + 1;
            if (m_good_run == RECOVER_CYCLES) begin
                m_mode = 1; m_bad_run = 0; m_fault = 1'b0; m_code = 2'b00;
                m_lamps = {light_M1, light_M2, light_MT, light_S};
            end
        end else if (m_mode == 1) begin
            if (!bad) begin
                m_bad_run = 0;
                m_lamps = {light_M1, light_M2, light_MT, light_S};
            end else begin
                m_bad_run++;
                m_lamps = ALL_RED;
                if (m_bad_run == FAULT_CYCLES) begin
                    m_mode = 2; m_age = 0; m_fault = 1'b1; m_code = {inv, conf};
                    m_lamps = {A, A, A, R};
                end
            end
        end else begin
            if (clear_fault && !bad) begin
                m_mode = 0; m_good_run = 0; m_lamps = ALL_RED;
            end else begin
                m_age++;
                m_lamps = (((m_age / BLINK_HALF) % 2) == 0) ? {A, A, A, R} : 12'h000;
            end
        end
    endtask

    task automatic set_in(input logic [11:0] v);
        {light_M1, light_M2, light_MT, light_S} = v;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("lamps", {lamp_M1, lamp_M2, lamp_MT, lamp_S}, m_lamps);
        check_eq("fault", {11'b0, fault}, {11'b0, m_fault});
        check_eq("fault_code", {10'b0, fault_code}, {10'b0, m_code});
    endtask

    logic [11:0] legal_tbl [6];
    logic [11:0] cur;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        legal_tbl[0] = {G, G, R, R};
        legal_tbl[1] = {G, A, R, R};
        legal_tbl[2] = {G, R, G, R};
        legal_tbl[3] = {A, R, A, R};
        legal_tbl[4] = {R, R, R, G};
        legal_tbl[5] = {R, R, R, A};

        rst = 1'b1; clear_fault = 1'b0;
        set_in({G, G, R, R});
        model_reset();
        #12;
        check_eq("reset_lamps", {lamp_M1, lamp_M2, lamp_MT, lamp_S}, ALL_RED);
        check_eq("reset_fault", {10'b0, fault, |fault_code}, 12'h000);
        rst = 1'b0;

        // Recovery after reset, then pass-through.
        repeat (5) tick();

        // Legal controller sequence.
        for (int i = 0; i < 6; i++) begin
            set_in(legal_tbl[i]);
            repeat (2) tick();
        end

        // Single conflicting cycle: masked, no latch.
        set_in({G, R, R, G});
        tick();
        set_in(legal_tbl[0]);
        repeat (3) tick();

        // Held M2/MT conflict: latch with conflict code, then flash.
        set_in({R, G, G, R});
        repeat (2) tick();
        check_eq("latch_code", {10'b0, fault_code}, 12'h001);
        repeat (10) tick();

        // Clear with an illegal encoding is refused.
        set_in({R, R, R, 3'b000});
        clear_fault = 1'b1;
        repeat (3) tick();
        // Clear with legal inputs: recovery, then pass-through.
        set_in(legal_tbl[0]);
        tick();
        clear_fault = 1'b0;
        repeat (5) tick();

        // Asynchronous reset during flash.
        set_in({R, G, G, R});
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_lamps", {lamp_M1, lamp_M2, lamp_MT, lamp_S}, ALL_RED);
        check_eq("async_rst_fault", {11'b0, fault}, 12'h000);
        model_reset();
        #2;
        rst = 1'b0;
        set_in(legal_tbl[2]);
        repeat (4) tick();

        // Random stimulus.
        cur = legal_tbl[0];
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 50) begin
                cur = legal_tbl[$urandom_range(0, 5)];
            end else if (r < 80) begin
                cur = cur;
            end else if (r < 90) begin
                cur = {G, R, R, R};
                cur[3*$urandom_range(0, 3) +: 3] = A;
                cur[3*$urandom_range(0, 3) +: 3] = G;
            end else begin
                cur = 12'($urandom);
            end
            set_in(cur);
            clear_fault = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
